// File: rtl/jtag_scan_master.sv
// JTAG initiator: replays TAP_RESET / IR scan / DR scan / idle-clock TMS sequences on
// TCK/TMS/TDI and captures TDO over the shift window into a single response word.
module jtag_scan_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [LEN_W-1:0]   cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_tdi_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_tdo_o,
  output logic               busy_o,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DivLast = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DivOne  = DIV_W'(1);
  localparam logic [LEN_W:0]   BitOne  = {{LEN_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StPre, StShift, StPost, StResp} state_e;
  typedef enum logic [1:0] {OpTapReset, OpIrScan, OpDrScan, OpIdleClk} op_e;

  state_e             state_q;
  op_e                op_q;
  logic [LEN_W-1:0]   len_q;
  logic [MAX_LEN-1:0] tdi_q;
  logic [DIV_W-1:0]   div_q;
  logic [2:0]         step_q;
  logic [LEN_W:0]     bit_q;

  state_e             nxt_state;
  logic [2:0]         nxt_step;
  logic [LEN_W:0]     nxt_bit;
  logic               nxt_tms;
  logic               nxt_tdi;
  logic               capture;

  assign cmd_ready_o = ~busy_o;

  // Index of the last preamble step; TAP_RESET replays its whole pattern here.
  function automatic logic [2:0] pre_last(op_e op);
    logic [2:0] r;
    case (op)
      OpTapReset: r = 3'd5;
      OpIrScan:   r = 3'd3;
      OpDrScan:   r = 3'd2;
      default:    r = 3'd0;
    endcase
    return r;
  endfunction

  function automatic logic pos_tms(op_e op, state_e st, logic [2:0] step,
                                   logic [LEN_W:0] idx, logic [LEN_W-1:0] len);
    logic t;
    t = 1'b0;
    case (st)
      StPre: begin
        case (op)
          OpTapReset: t = (step != 3'd5);
          OpIrScan:   t = (step < 3'd2);
          OpDrScan:   t = (step == 3'd0);
          default:    t = 1'b0;
        endcase
      end
      StShift: t = (op != OpIdleClk) && (idx == {1'b0, len});
      StPost:  t = (step == 3'd0);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Position of the TCK bit that follows the current one.
  always_comb begin
    nxt_state = state_q;
    nxt_step  = step_q;
    nxt_bit   = bit_q;
    case (state_q)
      StPre: begin
        if (step_q == pre_last(op_q)) begin
          if (op_q == OpTapReset) begin
            nxt_state = StResp;
          end else begin
            nxt_state = StShift;
            nxt_bit   = '0;
          end
        end else begin
          nxt_step = step_q + 3'd1;
        end
      end
      StShift: begin
        if (bit_q == {1'b0, len_q}) begin
          if (op_q == OpIdleClk) begin
            nxt_state = StResp;
          end else begin
            nxt_state = StPost;
            nxt_step  = 3'd0;
          end
        end else begin
          nxt_bit = bit_q + BitOne;
        end
      end
      StPost: begin
        if (step_q == 3'd1) begin
          nxt_state = StResp;
        end else begin
          nxt_step = step_q + 3'd1;
        end
      end
      default: ;
    endcase
    nxt_tms = pos_tms(op_q, nxt_state, nxt_step, nxt_bit, len_q);
    nxt_tdi = (nxt_state == StShift) && (op_q inside {OpIrScan, OpDrScan}) &&
              tdi_q[nxt_bit[LEN_W-1:0]];
    capture = (state_q == StShift) && (op_q inside {OpIrScan, OpDrScan});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      op_q        <= OpTapReset;
      len_q       <= '0;
      tdi_q       <= '0;
      div_q       <= '0;
      step_q      <= '0;
      bit_q       <= '0;
      busy_o      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_tdo_o   <= '0;
      tck_o       <= 1'b0;
      tms_o       <= 1'b1;
      tdi_o       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid_i && cmd_ready_o) begin
            op_q      <= op_e'(cmd_op_i);
            len_q     <= cmd_len_i;
            tdi_q     <= cmd_tdi_i;
            div_q     <= '0;
            step_q    <= '0;
            bit_q     <= '0;
            busy_o    <= 1'b1;
            rsp_tdo_o <= '0;
            tck_o     <= 1'b0;
            // Every sequence opens with TMS=1 except idle clocking; no op drives TDI first.
            tms_o     <= (cmd_op_i != 2'b11);
            tdi_o     <= 1'b0;
            state_q   <= (cmd_op_i == 2'b11) ? StShift : StPre;
          end
        end
        StPre, StShift, StPost: begin
          if (div_q == DivLast) begin
            div_q <= '0;
            if (!tck_o) begin
              tck_o <= 1'b1;
              if (capture) rsp_tdo_o[bit_q[LEN_W-1:0]] <= tdo_i;
            end else begin
              tck_o   <= 1'b0;
              state_q <= nxt_state;
              step_q  <= nxt_step;
              bit_q   <= nxt_bit;
              if (nxt_state == StResp) begin
                rsp_valid_o <= 1'b1;
                tdi_o       <= 1'b0;
              end else begin
                tms_o <= nxt_tms;
                tdi_o <= nxt_tdi;
              end
            end
          end else begin
            div_q <= div_q + DivOne;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: drives commands into the master, which talks to a
// behavioural 16-state TAP target (5-bit IR, IDCODE and BYPASS data registers).
module tb_jtag_scan_master;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned MAX_LEN = 64;
  localparam logic [31:0] IDCODE = 32'h2495_11C3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [5:0]  cmd_len = '0;
  logic [63:0] cmd_tdi = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_tdo;
  logic        busy;
  logic        tck, tms, tdi;
  logic        tdo = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtag_scan_master #(
    .CLK_DIV(CLK_DIV),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_op_i   (cmd_op),
    .cmd_len_i  (cmd_len),
    .cmd_tdi_i  (cmd_tdi),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_tdo_o  (rsp_tdo),
    .busy_o     (busy),
    .tck_o      (tck),
    .tms_o      (tms),
    .tdi_o      (tdi),
    .tdo_i      (tdo)
  );

  // ---------------- behavioural TAP target ----------------
  typedef enum int {
    TsReset, TsIdle, TsSelDr, TsCapDr, TsShDr, TsEx1Dr, TsPauDr, TsEx2Dr, TsUpdDr,
    TsSelIr, TsCapIr, TsShIr, TsEx1Ir, TsPauIr, TsEx2Ir, TsUpdIr
  } tap_e;

  tap_e        tap_st = TsReset;
  logic [4:0]  ir = 5'h01;
  logic [4:0]  ir_sr = '0;
  logic [63:0] dr_sr = '0;
  int          dr_len = 32;

  function automatic tap_e tap_next(tap_e s, logic m);
    case (s)
      TsReset: return m ? TsReset : TsIdle;
      TsIdle:  return m ? TsSelDr : TsIdle;
      TsSelDr: return m ? TsSelIr : TsCapDr;
      TsCapDr: return m ? TsEx1Dr : TsShDr;
      TsShDr:  return m ? TsEx1Dr : TsShDr;
      TsEx1Dr: return m ? TsUpdDr : TsPauDr;
      TsPauDr: return m ? TsEx2Dr : TsPauDr;
      TsEx2Dr: return m ? TsUpdDr : TsShDr;
      TsUpdDr: return m ? TsSelDr : TsIdle;
      TsSelIr: return m ? TsReset : TsCapIr;
      TsCapIr: return m ? TsEx1Ir : TsShIr;
      TsShIr:  return m ? TsEx1Ir : TsShIr;
      TsEx1Ir: return m ? TsUpdIr : TsPauIr;
      TsPauIr: return m ? TsEx2Ir : TsPauIr;
      TsEx2Ir: return m ? TsUpdIr : TsShIr;
      TsUpdIr: return m ? TsSelDr : TsIdle;
      default: return TsReset;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap_st)
      TsReset: ir = 5'h01;
      TsCapDr: begin
        dr_len = (ir == 5'h01) ? 32 : 1;
        dr_sr  = (ir == 5'h01) ? {32'd0, IDCODE} : 64'd0;
      end
      TsShDr: begin
        dr_sr = dr_sr >> 1;
        dr_sr[dr_len-1] = tdi;
      end
      TsCapIr: ir_sr = 5'b00001;
      TsShIr:  ir_sr = {tdi, ir_sr[4:1]};
      TsUpdIr: ir = ir_sr;
      default: ;
    endcase
    tap_st = tap_next(tap_st, tms);
  end

  always @(negedge tck) begin
    tdo = (tap_st == TsShDr) ? dr_sr[0] : (tap_st == TsShIr) ? ir_sr[0] : 1'b0;
  end

  // ---------------- TCK rising-edge monitor ----------------
  bit mon_tms_a [8192];
  bit mon_tdi_a [8192];
  int mon_cyc_a [8192];
  int mon_n = 0;
  int cyc = 0;
  bit tck_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (tck && !tck_prev) begin
      if (mon_n < 8192) begin
        mon_tms_a[mon_n] = tms;
        mon_tdi_a[mon_n] = tdi;
        mon_cyc_a[mon_n] = cyc;
      end
      mon_n++;
    end
    tck_prev = tck;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected TMS/TDI per TCK bit, straight from the sequence definitions.
  task automatic build_ref(input logic [1:0] op, input logic [5:0] len, input logic [63:0] d,
                           output logic [127:0] etms, output logic [127:0] etdi,
                           output int ecnt);
    int n;
    int pre;
    n = int'(len) + 1;
    etms = '0;
    etdi = '0;
    pre = 0;
    case (op)
      2'b00: begin etms[5:0] = 6'b011111; ecnt = 6; end
      2'b11: ecnt = n;
      default: begin
        if (op == 2'b01) begin etms[3:0] = 4'b0011; pre = 4; end
        else begin etms[2:0] = 3'b001; pre = 3; end
        for (int k = 0; k < n; k++) begin
          etms[pre+k] = (k == n - 1);
          etdi[pre+k] = d[k];
        end
        etms[pre+n]   = 1'b1;
        etms[pre+n+1] = 1'b0;
        ecnt = pre + n + 2;
      end
    endcase
  endtask

  // Target+master behaviour as stream arithmetic: selected register's old contents
  // come out first, followed by the bits just shifted in.
  logic [4:0] ir_track = 5'h01;

  task automatic model_cmd(input logic [1:0] op, input logic [5:0] len, input logic [63:0] d,
                           output logic [63:0] etdo, output int entck);
    int n;
    logic [63:0]  mask;
    logic [127:0] full;
    n = int'(len) + 1;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    etdo = '0;
    case (op)
      2'b00: begin entck = 6; ir_track = 5'h01; end
      2'b01: begin
        full = ({64'd0, d} << 5) | 128'd1;
        etdo = full[63:0] & mask;
        ir_track = full[n +: 5];
        entck = n + 6;
      end
      2'b10: begin
        full = (ir_track == 5'h01) ? (({64'd0, d} << 32) | {96'd0, IDCODE}) : ({64'd0, d} << 1);
        etdo = full[63:0] & mask;
        entck = n + 5;
      end
      default: entck = n;
    endcase
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [5:0] len,
                         input logic [63:0] d, input logic [63:0] etdo, input int entck,
                         input int rdy_dly);
    logic [127:0] etms, etdi, atms, atdi;
    int ecnt, base, cnt, n;
    bit pbad;
    logic [63:0] got;
    build_ref(op, len, d, etms, etdi, ecnt);
    @(negedge clk);
    base = mon_n;
    cmd_op = op;
    cmd_len = len;
    cmd_tdi = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_tdi = ~d;
    cmd_len = ~len;
    n = 1;
    while (!rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, entck * 2 * CLK_DIV + 1);
    chk({tag, " tck low at rsp"}, tck, 0);
    got = rsp_tdo;
    chk({tag, " rsp_tdo"}, got, etdo);
    cnt = mon_n - base;
    chk({tag, " tck count"}, cnt, entck);
    atms = '0;
    atdi = '0;
    pbad = 1'b0;
    for (int i = 0; i < cnt && i < 128 && base + i < 8192; i++) begin
      atms[i] = mon_tms_a[base+i];
      atdi[i] = mon_tdi_a[base+i];
      if (i > 0 && mon_cyc_a[base+i] - mon_cyc_a[base+i-1] != 2 * CLK_DIV) pbad = 1'b1;
    end
    chk({tag, " tck period bad"}, pbad, 0);
    chk({tag, " tms seq"}, atms, etms);
    chk({tag, " tdi seq"}, atdi, etdi);
    repeat (rdy_dly) @(negedge clk);
    chk({tag, " rsp held"}, {rsp_valid, rsp_tdo}, {1'b1, got});
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " busy/valid after hs"}, {busy, rsp_valid, cmd_ready}, 3'b001);
    chk({tag, " tap idle"}, tap_st, TsIdle);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [63:0] tdi;
    logic [63:0] exp_tdo;
    int          exp_ntck;
    logic [4:0]  exp_ir;
    bit          chk_byp;
  } vec_t;

  vec_t vecs [9];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] etdo;
    int entck, bad_v, bad_d, bad_r, bad_t;

    vecs[0] = '{2'b00, 6'd0,  64'h0,                   64'h0,                   6,  5'h01, 1'b0};
    vecs[1] = '{2'b01, 6'd4,  64'h1,                   64'h1,                   11, 5'h01, 1'b0};
    vecs[2] = '{2'b10, 6'd31, 64'h0,                   64'h0000_0000_2495_11C3, 37, 5'h01, 1'b0};
    vecs[3] = '{2'b01, 6'd4,  64'h1F,                  64'h1,                   11, 5'h1F, 1'b0};
    vecs[4] = '{2'b10, 6'd0,  64'h1,                   64'h0,                   6,  5'h1F, 1'b1};
    vecs[5] = '{2'b11, 6'd7,  64'hFFFF,                64'h0,                   8,  5'h1F, 1'b0};
    vecs[6] = '{2'b10, 6'd63, 64'hDEAD_BEEF_0123_4567, 64'hBD5B_7DDE_0246_8ACE, 69, 5'h1F, 1'b0};
    vecs[7] = '{2'b01, 6'd4,  64'h1,                   64'h1,                   11, 5'h01, 1'b0};
    vecs[8] = '{2'b10, 6'd63, 64'h0000_0000_A5A5_5A5A, 64'hA5A5_5A5A_2495_11C3, 69, 5'h01, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset outputs", {cmd_ready, rsp_valid, busy, tck, tms, tdi}, 6'b100010);
    chk("reset rsp_tdo", rsp_tdo, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset idle", {cmd_ready, rsp_valid, busy, tck, tms, tdi}, 6'b100010);

    for (int i = 0; i < 9; i++) begin
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].len, vecs[i].tdi, vecs[i].exp_tdo,
              vecs[i].exp_ntck, i % 3);
      chk($sformatf("vec%0d ir", i), ir, vecs[i].exp_ir);
      if (vecs[i].chk_byp) chk($sformatf("vec%0d bypass reg", i), dr_sr[0], 1);
      ir_track = vecs[i].exp_ir;
    end

    // Response back-pressure with a second command pending.
    @(negedge clk);
    cmd_op = 2'b10; cmd_len = 6'd31; cmd_tdi = '0; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    entck = 1;
    while (!rsp_valid && entck < 2000) begin @(negedge clk); entck++; end
    chk("bp first latency", entck, 37 * 2 * CLK_DIV + 1);
    cmd_op = 2'b11; cmd_len = 6'd3; cmd_valid = 1'b1;
    bad_v = 0; bad_d = 0; bad_r = 0; bad_t = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rsp_valid) bad_v++;
      if (rsp_tdo !== 64'h2495_11C3) bad_d++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) bad_r++;
      if (tck !== 1'b0) bad_t++;
    end
    chk("bp rsp_valid drops", bad_v, 0);
    chk("bp rsp_tdo unstable", bad_d, 0);
    chk("bp ready while busy", bad_r, 0);
    chk("bp tck while held", bad_t, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp ready after hs", {busy, cmd_ready, rsp_valid}, 3'b010);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp second accepted", busy, 1);
    entck = 1;
    while (!rsp_valid && entck < 2000) begin @(negedge clk); entck++; end
    chk("bp second latency", entck, 4 * 2 * CLK_DIV + 1);
    chk("bp second tdo", rsp_tdo, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset in the middle of a 64-bit DR shift.
    cmd_op = 2'b10; cmd_len = 6'd63; cmd_tdi = 64'h0123_4567_89AB_CDEF; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid-shift tap state", tap_st, TsShDr);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid-reset outputs", {cmd_ready, rsp_valid, busy, tck, tms, tdi}, 6'b100010);
    bad_v = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_valid || tck) bad_v++;
    end
    chk("no activity after reset", bad_v, 0);
    run_cmd("tap reset after abort", 2'b00, 6'd0, 64'h0, 64'h0, 6, 1);
    ir_track = 5'h01;
    chk("ir after tap reset", ir, 5'h01);

    // Randomised commands against the stream model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [5:0]  len;
      logic [63:0] d;
      op  = 2'($urandom_range(0, 3));
      len = (i % 4 == 0) ? 6'd63 : 6'($urandom_range(0, 63));
      d   = {$urandom, $urandom};
      model_cmd(op, len, d, etdo, entck);
      run_cmd($sformatf("rnd%0d op%0d len%0d", i, op, len), op, len, d, etdo, entck,
              int'($urandom_range(0, 3)));
      chk($sformatf("rnd%0d ir", i), ir, ir_track);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
